// File: rtl/add16_pkg.sv
// Shared types, constants and the adder16 behavioural reference.
// Ports: none (package imported by accumulator RTL and bench).
package add16_pkg;

    typedef enum logic [1:0] {
        ADD_SAT  = 2'b00,
        SUB_SAT  = 2'b01,
        NIB_WRAP = 2'b10,
        NIB_SAT  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;
    localparam logic signed [3:0]  NIB_MAX = 4'sh7;
    localparam logic signed [3:0]  NIB_MIN = 4'sh8;

    typedef struct packed {
        logic        ov;
        logic [15:0] sum;
    } add_res_t;

    // ov flags any saturation (full-width modes) or any
    // per-nibble signed overflow (nibble modes).
    function automatic add_res_t add16_ref(
        input logic [15:0] a,
        input logic [15:0] b,
        input mode_e       mode
    );
        add_res_t           r;
        logic signed [16:0] w;
        logic signed [4:0]  n;
        r = '0;
        w = '0;
        n = '0;
        unique case (mode)
            ADD_SAT, SUB_SAT: begin
                if (mode == ADD_SAT)
                    w = $signed({a[15], a}) + $signed({b[15], b});
                else
                    w = $signed({a[15], a}) - $signed({b[15], b});
                if (w > $signed({SAT_MAX[15], SAT_MAX})) begin
                    r.sum = SAT_MAX;
                    r.ov  = 1'b1;
                end else if (w < $signed({SAT_MIN[15], SAT_MIN})) begin
                    r.sum = SAT_MIN;
                    r.ov  = 1'b1;
                end else begin
                    r.sum = w[15:0];
                end
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    n = $signed({a[4*i+3], a[4*i +: 4]})
                      + $signed({b[4*i+3], b[4*i +: 4]});
                    if (mode == NIB_WRAP) begin
                        r.sum[4*i +: 4] = n[3:0];
                        if (n[4] != n[3]) r.ov = 1'b1;
                    end else if (n > $signed({NIB_MAX[3], NIB_MAX})) begin
                        r.sum[4*i +: 4] = NIB_MAX;
                        r.ov = 1'b1;
                    end else if (n < $signed({NIB_MIN[3], NIB_MIN})) begin
                        r.sum[4*i +: 4] = NIB_MIN;
                        r.ov = 1'b1;
                    end else begin
                        r.sum[4*i +: 4] = n[3:0];
                    end
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/add16_stream_accum_if.sv
// Bundle of command, operand, adder16 and result signals.
// master: accumulator side; slave: environment / adder side.
interface add16_stream_accum_if #(
    parameter int MAX_LEN = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             start_valid;
    logic             start_ready;
    logic [1:0]       start_mode;
    logic [LEN_W-1:0] start_len;
    logic [15:0]      start_init;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [1:0]       add_mode;
    logic [15:0]      add_sum;
    logic             add_ov;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic             out_ov;
    logic [LEN_W-1:0] out_count;
    logic             chk_err;

    modport master (
        input  start_valid, start_mode, start_len, start_init,
        input  in_valid, in_data, add_sum, add_ov, out_ready,
        output start_ready, in_ready, add_a, add_b, add_mode,
        output out_valid, out_sum, out_ov, out_count, chk_err
    );

    modport slave (
        output start_valid, start_mode, start_len, start_init,
        output in_valid, in_data, add_sum, add_ov, out_ready,
        input  start_ready, in_ready, add_a, add_b, add_mode,
        input  out_valid, out_sum, out_ov, out_count, chk_err
    );

endinterface

// File: rtl/add16_stream_accum_ctrl.sv
// IDLE/RUN/DONE sequencer: length clamp, element counters, handshakes.
// Ports: clk, reset, start/in/out handshakes, accept strobes, count.
module add16_accum_ctrl
    import add16_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    input  logic [LEN_W-1:0] start_len,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             start_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             start_acc,
    output logic             elem_acc,
    output logic [LEN_W-1:0] count
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_e           state;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_c;

    assign len_c     = (start_len > MAX_L) ? MAX_L : start_len;
    assign start_acc = start_ready & start_valid;
    assign elem_acc  = in_ready & in_valid;

    // Handshake outputs are registered alongside the state so
    // they change only on state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            remaining   <= '0;
            count       <= '0;
            start_ready <= 1'b1;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (start_valid) begin
                    count       <= '0;
                    remaining   <= len_c;
                    start_ready <= 1'b0;
                    if (len_c != '0) begin
                        state    <= S_RUN;
                        in_ready <= 1'b1;
                    end else begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_RUN: if (in_valid) begin
                    count     <= count + LEN_W'(1);
                    remaining <= remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state     <= S_DONE;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: if (out_ready) begin
                    state       <= S_IDLE;
                    out_valid   <= 1'b0;
                    start_ready <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    start_ready <= 1'b1;
                    in_ready    <= 1'b0;
                    out_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/add16_stream_accum.sv
// Streams operands through an external adder16 into one accumulator.
// Ports: clk, reset, bus (add16_stream_accum_if.master).
// Optional: ADD16_ACCUM_SELFCHECK_EN builds the chk_err adder checker.
module add16_stream_accum
    import add16_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input logic                  clk,
    input logic                  reset,
    add16_stream_accum_if.master bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [15:0]      acc;
    mode_e            mode_q;
    logic             ov_sticky;
    logic             start_acc;
    logic             elem_acc;
    logic [LEN_W-1:0] count;

    add16_accum_ctrl #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .start_valid (bus.start_valid),
        .start_len   (bus.start_len),
        .in_valid    (bus.in_valid),
        .out_ready   (bus.out_ready),
        .start_ready (bus.start_ready),
        .in_ready    (bus.in_ready),
        .out_valid   (bus.out_valid),
        .start_acc   (start_acc),
        .elem_acc    (elem_acc),
        .count       (count)
    );

    // in_ready is high exactly in RUN; elsewhere b is parked at 0.
    assign bus.add_a    = acc;
    assign bus.add_b    = bus.in_ready ? bus.in_data : 16'h0000;
    assign bus.add_mode = mode_q;

    assign bus.out_sum   = bus.out_valid ? acc : 16'h0000;
    assign bus.out_ov    = bus.out_valid & ov_sticky;
    assign bus.out_count = bus.out_valid ? count : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            mode_q    <= ADD_SAT;
            ov_sticky <= 1'b0;
        end else if (start_acc) begin
            acc       <= bus.start_init;
            mode_q    <= mode_e'(bus.start_mode);
            ov_sticky <= 1'b0;
        end else if (elem_acc) begin
            acc       <= bus.add_sum;
            ov_sticky <= ov_sticky | bus.add_ov;
        end
    end

`ifdef ADD16_ACCUM_SELFCHECK_EN
    add_res_t exp_r;
    logic     chk_q;

    assign exp_r = add16_ref(acc, bus.in_data, mode_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= 1'b0;
        end else if (start_acc) begin
            chk_q <= 1'b0;
        end else if (elem_acc && (exp_r != {bus.add_ov, bus.add_sum})) begin
            chk_q <= 1'b1;
        end
    end

    assign bus.chk_err = chk_q;
`else
    assign bus.chk_err = 1'b0;
`endif

endmodule
